wb_arbiter_2x1: RTL and testbench

WB_ARBITER_2X1 -- requirements
Module: wb_arbiter_2x1

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_if.sv | 23 ++
 rtl/wb_watchdog.sv | 28 ++
 rtl/wb_arbiter_2x1.sv | 112 +++++++++++
 tb/tb_wb_arbiter_2x1.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM state encoding,
// requester identifiers and the watchdog counter width.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TOUT = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

  localparam int WDOG_WIDTH = 16;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 classic bus bundle; master drives the request side, slave
// returns data and termination.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (output adr, cti, bte, dat_w, cyc, sel, stb, we,
                  input  dat_r, ack, err);
  modport slave  (input  adr, cti, bte, dat_w, cyc, sel, stb, we,
                  output dat_r, ack, err);
endinterface

// File: rtl/wb_watchdog.sv
// Counts consecutive stalled strobe cycles; expire pulses on the cycle the
// count would reach LIMIT while still stalled.
module wb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [WDOG_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expire = inc && (r_count == WDOG_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/wb_arbiter_2x1.sv
// Round-robin arbiter letting two Wishbone requesters share one slave, with a
// grant held for the whole CYC and a watchdog that ends hung slave cycles.
module wb_arbiter_2x1
  import wb_arbiter_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  wb_if.slave  m0,
  wb_if.slave  m1,
  wb_if.master s0
);

  arb_state_e r_state;
  master_id_t r_grant;
  master_id_t r_last_grant;
  master_id_t w_pick;

  logic w_req_any, w_gnt_cyc, w_busy, w_tout, w_route;
  logic w_inc, w_expire, w_ack, w_err;

  logic [WB_ADDR_WIDTH-1:0]   w_adr;
  logic [WB_DATA_WIDTH-1:0]   w_dat_w;
  logic [WB_DATA_WIDTH/8-1:0] w_sel;
  logic [2:0]                 w_cti;
  logic [1:0]                 w_bte;
  logic                       w_stb, w_we;

  assign w_req_any = m0.cyc | m1.cyc;

  always_comb begin
    // NOTE: default first so every path assigns w_pick and no latch is inferred.
    w_pick = M0;
    if (m0.cyc && m1.cyc) begin
      w_pick = (r_last_grant == M0) ? M1 : M0;
    end else if (m1.cyc) begin
      w_pick = M1;
    end
  end

  // Outputs are gated by rst so an in-flight transfer is dropped at once.
  assign w_busy  = (r_state == BUSY) && !rst;
  assign w_tout  = (r_state == TOUT) && !rst;
  assign w_route = w_busy | w_tout;

  assign w_gnt_cyc = (r_grant == M1) ? m1.cyc   : m0.cyc;
  assign w_adr     = (r_grant == M1) ? m1.adr   : m0.adr;
  assign w_dat_w   = (r_grant == M1) ? m1.dat_w : m0.dat_w;
  assign w_sel     = (r_grant == M1) ? m1.sel   : m0.sel;
  assign w_cti     = (r_grant == M1) ? m1.cti   : m0.cti;
  assign w_bte     = (r_grant == M1) ? m1.bte   : m0.bte;
  assign w_stb     = (r_grant == M1) ? m1.stb   : m0.stb;
  assign w_we      = (r_grant == M1) ? m1.we    : m0.we;

  assign s0.adr   = w_route ? w_adr   : '0;
  assign s0.dat_w = w_route ? w_dat_w : '0;
  assign s0.sel   = w_route ? w_sel   : '0;
  assign s0.cti   = w_route ? w_cti   : '0;
  assign s0.bte   = w_route ? w_bte   : '0;
  assign s0.we    = w_route & w_we;
  assign s0.cyc   = w_busy & w_gnt_cyc;
  assign s0.stb   = w_busy & w_stb;

  // The timeout cycle reports ERR to the owner in place of a slave response.
  assign w_ack = w_busy & s0.ack;
  assign w_err = (w_busy & s0.err) | w_tout;

  assign m0.ack   = (r_grant == M0) & w_ack;
  assign m0.err   = (r_grant == M0) & w_err;
  assign m0.dat_r = (w_busy && r_grant == M0) ? s0.dat_r : '0;
  assign m1.ack   = (r_grant == M1) & w_ack;
  assign m1.err   = (r_grant == M1) & w_err;
  assign m1.dat_r = (w_busy && r_grant == M1) ? s0.dat_r : '0;

  assign w_inc = w_busy & s0.stb & ~s0.ack & ~s0.err;

  wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!w_inc),
    .inc    (w_inc),
    .expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= M0;
      r_last_grant <= M1;
    end else begin
      case (r_state)
        IDLE: if (w_req_any) begin
          r_state      <= BUSY;
          r_grant      <= w_pick;
          r_last_grant <= w_pick;
        end
        BUSY: begin
          if (!w_gnt_cyc)    r_state <= IDLE;
          else if (w_expire) r_state <= TOUT;
        end
        TOUT:    r_state <= w_gnt_cyc ? BUSY : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Bench for wb_arbiter_2x1: ownership-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_arbiter_2x1;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
  wb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();

  // Zero-wait slave whose ACK/ERR enables are steered by the stimulus.
  logic        slv_en    = 1'b0;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = '0;
  assign s0_if.ack   = s0_if.cyc & s0_if.stb & slv_en;
  assign s0_if.err   = s0_if.cyc & s0_if.stb & slv_err;
  assign s0_if.dat_r = slv_rdata;

  wb_arbiter_2x1 #(
    .WB_ADDR_WIDTH (AW),
    .WB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s0  (s0_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_ctl(input logic [31:0] d, input logic [3:0] s,
                                           input logic w, input logic [2:0] c, input logic [1:0] b);
    return {22'd0, d, s, w, c, b};
  endfunction

  // Reference model: who owns the slave, who went last, stall count, timeout flag.
  int owner = -1;
  int last  = 1;
  int cnt   = 0;
  bit tout  = 1'b0;

  always @(negedge clk) begin : scoreboard
    logic        c [2];
    logic        s [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0]  sl[2];
    logic [2:0]  ct[2];
    logic [1:0]  bt[2];
    logic        live, e_cyc, e_stb, s_ack, s_err;
    int          oi;
    c[0] = m0_if.cyc; s[0] = m0_if.stb; w[0] = m0_if.we; a[0] = m0_if.adr;
    d[0] = m0_if.dat_w; sl[0] = m0_if.sel; ct[0] = m0_if.cti; bt[0] = m0_if.bte;
    c[1] = m1_if.cyc; s[1] = m1_if.stb; w[1] = m1_if.we; a[1] = m1_if.adr;
    d[1] = m1_if.dat_w; sl[1] = m1_if.sel; ct[1] = m1_if.cti; bt[1] = m1_if.bte;

    oi    = (owner < 0) ? 0 : owner;
    live  = !rst && (owner >= 0);
    e_cyc = live && !tout && c[oi];
    e_stb = live && !tout && s[oi];
    s_ack = e_cyc && e_stb && slv_en;
    s_err = e_cyc && e_stb && slv_err;

    check("s0_cyc", s0_if.cyc, e_cyc);
    check("s0_stb", s0_if.stb, e_stb);
    if (!live) begin
      check("s0_adr_idle", s0_if.adr, 0);
      check("s0_ctl_idle", pack_ctl(s0_if.dat_w, s0_if.sel, s0_if.we, s0_if.cti, s0_if.bte), 0);
    end else if (!tout) begin
      check("s0_adr", s0_if.adr, a[oi]);
      check("s0_ctl", pack_ctl(s0_if.dat_w, s0_if.sel, s0_if.we, s0_if.cti, s0_if.bte),
            pack_ctl(d[oi], sl[oi], w[oi], ct[oi], bt[oi]));
    end
    check("m0_resp", {m0_if.ack, m0_if.err},
          {live && !tout && owner == 0 && s_ack, live && owner == 0 && (tout || s_err)});
    check("m1_resp", {m1_if.ack, m1_if.err},
          {live && !tout && owner == 1 && s_ack, live && owner == 1 && (tout || s_err)});
    check("m0_dat_r", m0_if.dat_r, (live && !tout && owner == 0) ? slv_rdata : 32'd0);
    check("m1_dat_r", m1_if.dat_r, (live && !tout && owner == 1) ? slv_rdata : 32'd0);

    if (rst) begin
      owner = -1; last = 1; cnt = 0; tout = 1'b0;
    end else if (owner < 0) begin
      if (c[0] || c[1]) begin
        owner = (c[0] && c[1]) ? 1 - last : (c[0] ? 0 : 1);
        last  = owner;
      end
      cnt = 0;
    end else if (tout) begin
      tout = 1'b0;
      cnt  = 0;
      if (!c[owner]) owner = -1;
    end else if (!c[owner]) begin
      owner = -1;
      cnt   = 0;
    end else if (s[owner] && !s_ack && !s_err) begin
      if (cnt == TO - 1) begin
        tout = 1'b1;
        cnt  = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_w = dat; m0_if.cti = cti; m0_if.sel = 4'hF; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_w = dat; m1_if.cti = cti; m1_if.sel = 4'h3; m1_if.bte = 2'b01;
    end
  endtask

  int exp_ord[6] = '{0, 1, 0, 1, 0, 1};
  int order[$];

  initial begin
    int  done0, done1;
    bit  up0, up1, a0, a1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(2);
    rst = 1'b0;
    at_neg();
    check("rst_after_s0_cyc", s0_if.cyc, 0);
    check("rst_after_acks", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 0);
    tick();

    // Single read: s0 follows one cycle after m0.CYC, data and ACK reach m0.
    slv_en = 1'b1; slv_rdata = 32'hDEAD_BEEF;
    drive(0, 1, 1, 0, 32'h100, 0, 0);
    at_neg();
    check("t1_idle_s0_cyc", s0_if.cyc, 0);
    tick();
    at_neg();
    check("t1_s0_cyc", s0_if.cyc, 1);
    check("t1_s0_adr", s0_if.adr, 32'h100);
    check("t1_m0_ack", m0_if.ack, 1);
    check("t1_m0_dat_r", m0_if.dat_r, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(2);

    // Tie straight out of reset: m0 first, m1 after a drop plus an idle cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    slv_rdata = 32'h0BAD_F00D;
    drive(0, 1, 1, 0, 32'h110, 0, 0);
    drive(1, 1, 1, 1, 32'h210, 32'h55, 0);
    tick();
    at_neg();
    check("t2_m0_ack", {m0_if.ack, m1_if.ack}, 2'b10);
    check("t2_s0_adr_m0", s0_if.adr, 32'h110);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("t2_m1_stall_a", m1_if.ack, 0);
    tick();
    at_neg();
    check("t2_idle_gap", {s0_if.cyc, m1_if.ack}, 0);
    tick();
    at_neg();
    check("t2_m1_ack", m1_if.ack, 1);
    check("t2_s0_adr_m1", s0_if.adr, 32'h210);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(2);

    // Fairness: both keep requesting three single transfers each.
    done0 = 0; done1 = 0; up0 = 1'b1; up1 = 1'b1;
    for (int i = 0; i < 40 && (done0 < 3 || done1 < 3); i++) begin
      drive(0, up0, up0, 0, 32'h200 + done0, 0, 0);
      drive(1, up1, up1, 1, 32'h300 + done1, 32'hA0 + done1, 0);
      at_neg();
      a0 = m0_if.ack; a1 = m1_if.ack;
      if (a0) order.push_back(0);
      if (a1) order.push_back(1);
      tick();
      if (up0 && a0) begin done0++; up0 = 1'b0; end
      else if (!up0 && done0 < 3) up0 = 1'b1;
      if (up1 && a1) begin done1++; up1 = 1'b0; end
      else if (!up1 && done1 < 3) up1 = 1'b1;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    check("t3_grant_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) check("t3_grant_order", order[i], exp_ord[i]);
    tick(2);

    // Burst lock: m1 keeps the slave for all four beats while m0 waits.
    drive(1, 1, 1, 0, 32'h400, 0, 3'b010);
    tick();
    drive(0, 1, 1, 0, 32'h500, 0, 0);
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, 1, 0, 32'h400 + 4 * b, 0, (b == 3) ? 3'b111 : 3'b010);
      at_neg();
      check("t4_beat_acks", {m1_if.ack, m0_if.ack}, 2'b10);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("t4_m0_wait_drop", m0_if.ack, 0);
    tick();
    at_neg();
    check("t4_m0_wait_idle", m0_if.ack, 0);
    tick();
    at_neg();
    check("t4_m0_served", m0_if.ack, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(2);

    // Timeout: slave never answers, ERR lands 8 cycles after s0.STB rises.
    slv_en = 1'b0;
    drive(0, 1, 1, 0, 32'h600, 0, 0);
    tick();
    for (int i = 0; i < TO; i++) begin
      at_neg();
      check("t5_wait", {s0_if.cyc, m0_if.err}, 2'b10);
      tick();
    end
    at_neg();
    check("t5_tout_err", {m0_if.err, m0_if.ack}, 2'b10);
    check("t5_tout_s0", {s0_if.cyc, s0_if.stb}, 2'b00);
    tick();
    at_neg();
    check("t5_rebusy", {s0_if.cyc, m0_if.err}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    tick(2);

    // ACK on the limit cycle wins over the watchdog.
    drive(0, 1, 1, 1, 32'h700, 32'h1234, 0);
    tick();
    tick(TO - 1);
    slv_en = 1'b1;
    at_neg();
    check("t6_ack_at_limit", {m0_if.ack, m0_if.err}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("t6_no_tout", m0_if.err, 0);
    tick(2);

    // Slave ERR is forwarded only to the owner.
    slv_en = 1'b0; slv_err = 1'b1;
    drive(1, 1, 1, 0, 32'h780, 0, 0);
    tick();
    at_neg();
    check("t7_err_fwd", {m1_if.err, m1_if.ack, m0_if.err}, 3'b100);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    slv_err = 1'b0;
    tick(2);

    // Reset on beat 2 of an m1 burst: dropped at once, no ERR, m0 wins next tie.
    slv_en = 1'b1;
    drive(1, 1, 1, 0, 32'h800, 0, 3'b010);
    tick();
    tick(2);
    rst = 1'b1;
    at_neg();
    check("t8_in_reset", {s0_if.cyc, m1_if.err, m1_if.ack}, 0);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    at_neg();
    check("t8_after_reset", {s0_if.cyc, m1_if.err}, 0);
    tick();
    drive(0, 1, 1, 0, 32'h900, 0, 0);
    drive(1, 1, 1, 0, 32'hA00, 0, 0);
    tick();
    at_neg();
    check("t8_tie_m0", {m0_if.ack, m1_if.ack}, 2'b10);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
